// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the Ibex fetch and data ports.
// Out-of-window accesses are granted locally and answered with an error response.
module mem_port_arbiter #(
   parameter logic [31:0] MemStart = 32'h0000_0000,
   parameter int          MemSize  = 8192,
   parameter int          AddrW    = $clog2(MemSize / 4)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             instr_req_i,
   input  logic [31:0]      instr_addr_i,
   output logic             instr_gnt_o,
   output logic             instr_rvalid_o,
   output logic [31:0]      instr_rdata_o,
   output logic             instr_err_o,
   input  logic             data_req_i,
   input  logic             data_we_i,
   input  logic [3:0]       data_be_i,
   input  logic [31:0]      data_addr_i,
   input  logic [31:0]      data_wdata_i,
   output logic             data_gnt_o,
   output logic             data_rvalid_o,
   output logic [31:0]      data_rdata_o,
   output logic             data_err_o,
   output logic             mem_req_o,
   input  logic             mem_gnt_i,
   output logic             mem_we_o,
   output logic [3:0]       mem_be_o,
   output logic [AddrW-1:0] mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   input  logic [31:0]      mem_rdata_i
);

   localparam logic [0:0] PORT_INSTR = 1'b0;
   localparam logic [0:0] PORT_DATA  = 1'b1;
   localparam logic [31:0] MEM_SIZE_W = 32'(MemSize);

   logic [0:0]  prio_r;
   logic        resp_v_r;
   logic [0:0]  resp_owner_r;
   logic        resp_err_r;

   logic [31:0] instr_off_s;
   logic [31:0] data_off_s;
   logic        instr_in_range_s;
   logic        data_in_range_s;
   logic        any_req_s;
   logic        both_req_s;
   logic [0:0]  sel_port_s;
   logic        sel_in_range_s;
   logic        grant_s;
   logic        instr_resp_s;
   logic        data_resp_s;

   // Window decode: unsigned offset compare also rejects addresses below MemStart.
   always_comb begin
      instr_off_s      = instr_addr_i - MemStart;
      data_off_s       = data_addr_i - MemStart;
      instr_in_range_s = (instr_off_s < MEM_SIZE_W);
      data_in_range_s  = (data_off_s < MEM_SIZE_W);
   end

   // Port selection and grant generation; all request-side outputs are held low in reset.
   always_comb begin
      any_req_s      = 1'b0;
      both_req_s     = 1'b0;
      sel_port_s     = PORT_INSTR;
      sel_in_range_s = 1'b0;
      grant_s        = 1'b0;
      if (rst_i) begin
         any_req_s  = 1'b0;
         both_req_s = 1'b0;
      end else begin
         any_req_s  = instr_req_i | data_req_i;
         both_req_s = instr_req_i & data_req_i;
      end

      case ({instr_req_i, data_req_i})
         2'b01:   sel_port_s = PORT_DATA;
         2'b10:   sel_port_s = PORT_INSTR;
         2'b11:   sel_port_s = prio_r;
         default: sel_port_s = PORT_INSTR;
      endcase

      if (sel_port_s == PORT_DATA) begin
         sel_in_range_s = data_in_range_s;
      end else begin
         sel_in_range_s = instr_in_range_s;
      end

      // Out-of-window accesses never wait on the RAM.
      if (!any_req_s) begin
         grant_s = 1'b0;
      end else if (sel_in_range_s) begin
         grant_s = mem_gnt_i;
      end else begin
         grant_s = 1'b1;
      end
   end

   // RAM-side drive; everything is zero unless a RAM access is actually requested.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = {AddrW{1'b0}};
      mem_wdata_o = 32'h0000_0000;
      instr_gnt_o = grant_s & (sel_port_s == PORT_INSTR);
      data_gnt_o  = grant_s & (sel_port_s == PORT_DATA);
      if (any_req_s && sel_in_range_s) begin
         mem_req_o = 1'b1;
         if (sel_port_s == PORT_DATA) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_off_s[AddrW+1:2];
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_off_s[AddrW+1:2];
            mem_wdata_o = 32'h0000_0000;
         end
      end else begin
         mem_req_o = 1'b0;
      end
   end

   // Priority pointer and one-deep response stage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_r       <= PORT_DATA;
         resp_v_r     <= 1'b0;
         resp_owner_r <= PORT_INSTR;
         resp_err_r   <= 1'b0;
      end else begin
         if (grant_s && both_req_s) begin
            prio_r <= (sel_port_s == PORT_DATA) ? PORT_INSTR : PORT_DATA;
         end else begin
            prio_r <= prio_r;
         end
         resp_v_r <= grant_s;
         if (grant_s) begin
            resp_owner_r <= sel_port_s;
            resp_err_r   <= ~sel_in_range_s;
         end else begin
            resp_owner_r <= resp_owner_r;
            resp_err_r   <= 1'b0;
         end
      end
   end

   // Response steering: data and error reach only the owning port.
   always_comb begin
      instr_resp_s   = resp_v_r & (resp_owner_r == PORT_INSTR);
      data_resp_s    = resp_v_r & (resp_owner_r == PORT_DATA);
      instr_rvalid_o = instr_resp_s;
      data_rvalid_o  = data_resp_s;
      instr_err_o    = instr_resp_s & resp_err_r;
      data_err_o     = data_resp_s & resp_err_r;
      if (instr_resp_s && !resp_err_r) begin
         instr_rdata_o = mem_rdata_i;
      end else begin
         instr_rdata_o = 32'h0000_0000;
      end
      if (data_resp_s && !resp_err_r) begin
         data_rdata_o = mem_rdata_i;
      end else begin
         data_rdata_o = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a byte-enable RAM model
// that returns read data one cycle after an accepted access.
module tb_mem_port_arbiter;

   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          instr_req_i;
   logic [31:0]   instr_addr_i;
   logic          instr_gnt_o;
   logic          instr_rvalid_o;
   logic [31:0]   instr_rdata_o;
   logic          instr_err_o;
   logic          data_req_i;
   logic          data_we_i;
   logic [3:0]    data_be_i;
   logic [31:0]   data_addr_i;
   logic [31:0]   data_wdata_i;
   logic          data_gnt_o;
   logic          data_rvalid_o;
   logic [31:0]   data_rdata_o;
   logic          data_err_o;
   logic          mem_req_o;
   logic          mem_gnt_i;
   logic          mem_we_o;
   logic [3:0]    mem_be_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [31:0]   mem_rdata_i;

   logic [31:0] ram [0:(1<<AW)-1];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MemStart(32'h0000_0000), .MemSize(8192)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   // Single-port RAM model with byte enables and one-cycle read latency.
   always @(posedge clk) begin
      if (mem_req_o && mem_gnt_i) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
         end else begin
            mem_rdata_i <= ram[mem_addr_o];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; instr_req_i = 1'b0; instr_addr_i = 32'h0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
      data_addr_i = 32'h0; data_wdata_i = 32'h0; mem_gnt_i = 1'b1;
      step(); step();
      chk("reset_igv", {instr_gnt_o, instr_rvalid_o, instr_err_o}, 32'h0);
      chk("reset_dgv", {data_gnt_o, data_rvalid_o, data_err_o}, 32'h0);
      chk("reset_mem", {mem_req_o, mem_we_o, mem_be_o}, 32'h0);
      chk("reset_rdata", instr_rdata_o | data_rdata_o, 32'h0);
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_instr_read();
      instr_req_i = 1'b1; instr_addr_i = 32'h0000_0080;
      #1;
      chk("ifetch_gnt", {31'h0, instr_gnt_o}, 32'h1);
      chk("ifetch_memreq", {31'h0, mem_req_o}, 32'h1);
      chk("ifetch_addr", {21'h0, mem_addr_o}, 32'h20);
      chk("ifetch_we_be", {27'h0, mem_we_o, mem_be_o}, 32'h0F);
      step();
      instr_req_i = 1'b0;
      chk("ifetch_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h2);
      chk("ifetch_rdata", instr_rdata_o, 32'h0000_0013);
      chk("ifetch_err", {31'h0, instr_err_o}, 32'h0);
      step();
   endtask

   task automatic test_round_robin();
      logic exp_d;
      instr_req_i = 1'b1; instr_addr_i = 32'h0000_0080;
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0000_0104;
      for (int i = 0; i < 6; i++) begin
         exp_d = (i % 2 == 0);
         #1;
         chk("rr_gnt", {30'h0, data_gnt_o, instr_gnt_o}, {30'h0, exp_d, ~exp_d});
         step();
         chk("rr_rvalid", {30'h0, data_rvalid_o, instr_rvalid_o}, {30'h0, exp_d, ~exp_d});
         chk("rr_rdata", exp_d ? data_rdata_o : instr_rdata_o,
             exp_d ? 32'h1122_3344 : 32'h0000_0013);
      end
      instr_req_i = 1'b0; data_req_i = 1'b0;
      step();
   endtask

   task automatic test_write_merge();
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
      data_addr_i = 32'h0000_0104; data_wdata_i = 32'hAABB_CCDD;
      #1;
      chk("wr_gnt", {31'h0, data_gnt_o}, 32'h1);
      chk("wr_mem", {26'h0, mem_req_o, mem_we_o, mem_be_o}, 32'h33);
      chk("wr_addr", {21'h0, mem_addr_o}, 32'h41);
      chk("wr_wdata", mem_wdata_o, 32'hAABB_CCDD);
      step();
      chk("wr_rvalid", {31'h0, data_rvalid_o}, 32'h1);
      data_we_i = 1'b0; data_be_i = 4'hF;
      #1;
      chk("rd_we", {30'h0, mem_req_o, mem_we_o}, 32'h2);
      step();
      data_req_i = 1'b0;
      chk("rd_merged", data_rdata_o, 32'h1122_CCDD);
      step();
   endtask

   task automatic test_out_of_range();
      mem_gnt_i = 1'b0;
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_1FFC;
      #1;
      chk("edge_in_range", {20'h0, mem_req_o, mem_addr_o}, {20'h0, 1'b1, 11'h7FF});
      data_addr_i = 32'h0000_2000;
      #1;
      chk("oor_gnt", {30'h0, data_gnt_o, mem_req_o}, 32'h2);
      step();
      data_req_i = 1'b0; mem_gnt_i = 1'b1;
      chk("oor_resp", {29'h0, data_rvalid_o, data_err_o, instr_rvalid_o}, 32'h6);
      chk("oor_rdata", data_rdata_o, 32'h0);
      step();
      chk("oor_clear", {30'h0, data_rvalid_o, data_err_o}, 32'h0);
   endtask

   task automatic test_stall();
      instr_req_i = 1'b1; instr_addr_i = 32'h0000_0080;
      data_req_i = 1'b1; data_addr_i = 32'h0000_0104;
      #1;
      chk("stall_pre_gnt", {30'h0, data_gnt_o, instr_gnt_o}, 32'h2);
      step();
      mem_gnt_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_gnt", {29'h0, mem_req_o, data_gnt_o, instr_gnt_o}, 32'h4);
         step();
         chk("stall_rvalid", {30'h0, data_rvalid_o, instr_rvalid_o}, 32'h0);
      end
      mem_gnt_i = 1'b1;
      #1;
      chk("stall_release", {30'h0, data_gnt_o, instr_gnt_o}, 32'h1);
      step();
      instr_req_i = 1'b0; data_req_i = 1'b0;
      chk("stall_resp", {30'h0, data_rvalid_o, instr_rvalid_o}, 32'h1);
      chk("stall_rdata", instr_rdata_o, 32'h0000_0013);
      step();
   endtask

   task automatic test_reset_mid();
      instr_req_i = 1'b1; data_req_i = 1'b1;
      #1;
      chk("rst_pre_gnt", {30'h0, data_gnt_o, instr_gnt_o}, 32'h2);
      step();
      rst_i = 1'b1;
      #1;
      chk("rst_gnt_blocked", {29'h0, mem_req_o, data_gnt_o, instr_gnt_o}, 32'h0);
      step();
      chk("rst_no_rvalid", {30'h0, data_rvalid_o, instr_rvalid_o}, 32'h0);
      rst_i = 1'b0;
      #1;
      chk("rst_prio_data", {30'h0, data_gnt_o, instr_gnt_o}, 32'h2);
      step();
      instr_req_i = 1'b0; data_req_i = 1'b0;
      chk("rst_after_resp", {30'h0, data_rvalid_o, instr_rvalid_o}, 32'h2);
      step();
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
      ram[32'h20] = 32'h0000_0013;
      ram[32'h41] = 32'h1122_3344;
      mem_rdata_i = 32'h0;
      test_reset();
      test_instr_read();
      test_round_robin();
      test_write_merge();
      test_out_of_range();
      test_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port SRAM between the Ibex instruction fetch port and the Ibex data port.
- Both host ports use the Ibex req/gnt/rvalid protocol.
- Round-robin arbitration when both ports request in the same cycle.
- Accesses outside the SRAM window complete with an error response and never reach the RAM.
- Sits between ibex_top and a single-port RAM, in place of a dual-port RAM.

Parameters:
MemStart, 32'h00000000, byte base address of the SRAM window
MemSize, 8192, SRAM size in bytes; power of two, at least 4
AddrW, $clog2(MemSize/4), width of the RAM word address

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
instr_req_i  in  1  fetch request
instr_addr_i  in  32  fetch byte address
instr_gnt_o  out  1  fetch request accepted
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch read data
instr_err_o  out  1  fetch bus error (valid with rvalid)
data_req_i  in  1  load/store request
data_we_i  in  1  1 = write
data_be_i  in  4  byte enables
data_addr_i  in  32  byte address
data_wdata_i  in  32  write data
data_gnt_o  out  1  load/store request accepted
data_rvalid_o  out  1  load/store response valid
data_rdata_o  out  32  load read data
data_err_o  out  1  load/store bus error (valid with rvalid)
mem_req_o  out  1  RAM access strobe
mem_gnt_i  in  1  RAM accepts the access this cycle
mem_we_o  out  1  RAM write enable
mem_be_o  out  4  RAM byte enables
mem_addr_o  out  AddrW  RAM word address
mem_wdata_o  out  32  RAM write data
mem_rdata_i  in  32  RAM read data, valid exactly 1 cycle after an accepted access

Behaviour:
- Reset: all outputs 0; prio_q = DATA; response stage cleared.
- Asserting rst_i mid-operation discards any pending response. rvalid outputs are 0 on the cycle after rst_i is sampled high.
- Address decode: in_range = ((addr - MemStart) < MemSize), compared as unsigned 32-bit. mem_addr_o = (addr - MemStart)[AddrW+1:2]; low two address bits are ignored.
- Arbitration (combinational, same cycle):
  - Only one port requests: that port is selected.
  - Both request: the port named by prio_q is selected.
- Selected port, in-range address:
  - mem_req_o = 1, with that port's we/be/addr/wdata driven to the RAM.
  - Instruction port drives we = 0, be = 4'hF, wdata = 0.
  - gnt to the selected port = mem_gnt_i.
  - The other port's gnt = 0.
- Selected port, out-of-range address: mem_req_o = 0; gnt to that port = 1 unconditionally. RAM is never touched.
- prio_q update: on any granted access (RAM or error) while both ports requested, prio_q flips to the non-granted port. Otherwise prio_q holds.
- Response stage (registers): on a grant, capture resp_v = 1, resp_owner = port, resp_err = !in_range. Otherwise resp_v = 0.
- Response latency: exactly 1 cycle after the grant.
  - rvalid asserted only toward resp_owner.
  - rdata = mem_rdata_i when !resp_err; rdata = 0 when resp_err.
  - err = resp_err.
  - Non-owner rdata = 0.
- Throughput: one grant per cycle; back-to-back grants allowed. The response of grant N coincides with grant N+1.
- mem_gnt_i = 0: no grant issued. Request and arbitration decision hold; prio_q unchanged.
- Host ports may change or withdraw requests freely between cycles; the block holds no state for ungranted requests.
- Write responses: rvalid = 1 with rdata = 0 is acceptable. The bench checks rdata only for reads.

Test Plan:
- Reset, then instr read 0x80 with RAM word 0x20 = 0x00000013 -> instr_gnt_o = 1 same cycle; next cycle instr_rvalid_o = 1, instr_rdata_o = 0x00000013, data_rvalid_o = 0.
- Both ports request continuously for 6 cycles, mem_gnt_i = 1 -> grants D,I,D,I,D,I; each rvalid follows its own grant by 1 cycle, never to the wrong port.
- Data write be = 4'b0011, addr 0x104, wdata 0xAABBCCDD, then read 0x104 -> mem_be_o = 0011, mem_addr_o = 0x41, mem_we_o = 1; read returns the RAM model's merged word.
- Data read 0x2000 (MemSize = 8192) -> data_gnt_o = 1, mem_req_o = 0; next cycle data_rvalid_o = 1, data_err_o = 1, data_rdata_o = 0.
- mem_gnt_i held 0 for 3 cycles with both ports requesting -> no gnt, no rvalid, prio_q unchanged; on release, the port named by prio_q is granted first.
- Grant issued, then rst_i = 1 on the next edge -> no rvalid appears; after release, prio_q = DATA.
